// File: rtl/l1_snp_rsp_ctrl.sv
// ---------------------------------------------------------------------------
// l1_snp_rsp_ctrl
//
// L1-side snoop responder. It accepts one downstream snoop request
// (SDREQ_RD / SDREQ_RFO / SDREQ_INV) at a time and looks the line up in the
// L1 tag array. It applies the MESI downgrade or invalidate. When the line is
// MODIFIED it also reads the line so it can be flushed with the response.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   sureq_valid/ready/op/addr snoop request channel from the bus
//   lkup_valid/addr           tag lookup strobe and address
//   lkup_hit/st               tag result, one cycle after lkup_valid
//   dat_rd_en/addr            data array read strobe and address
//   dat_rd_data               line data, one cycle after dat_rd_en
//   upd_valid/addr/st         one-cycle MESI state write
//   sdrsp_valid/ready         snoop response handshake
//   sdrsp_rsp                 0 MISS, 1 HIT_CLEAN, 2 HIT_DIRTY
//   sdrsp_data                flushed line, meaningful with HIT_DIRTY
//   snp_busy                  transaction in flight (FSM not IDLE)
// ---------------------------------------------------------------------------
module l1_snp_rsp_ctrl #(
    parameter int AW = 32,
    parameter int LW = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sureq_valid,
    output logic          sureq_ready,
    input  logic [2:0]    sureq_op,
    input  logic [AW-1:0] sureq_addr,
    output logic          lkup_valid,
    output logic [AW-1:0] lkup_addr,
    input  logic          lkup_hit,
    input  logic [2:0]    lkup_st,
    output logic          dat_rd_en,
    output logic [AW-1:0] dat_rd_addr,
    input  logic [LW-1:0] dat_rd_data,
    output logic          upd_valid,
    output logic [AW-1:0] upd_addr,
    output logic [2:0]    upd_st,
    output logic          sdrsp_valid,
    input  logic          sdrsp_ready,
    output logic [1:0]    sdrsp_rsp,
    output logic [LW-1:0] sdrsp_data,
    output logic          snp_busy
);

    // Snoop op encodings (shared with the request controller)
    localparam logic [2:0] SDREQ_RD  = 3'd1;
    localparam logic [2:0] SDREQ_RFO = 3'd2;
    localparam logic [2:0] SDREQ_INV = 3'd3;

    // MESI encodings
    localparam logic [2:0] MESI_I = 3'd0;
    localparam logic [2:0] MESI_S = 3'd1;
    localparam logic [2:0] MESI_E = 3'd2;
    localparam logic [2:0] MESI_M = 3'd3;

    // Response codes
    localparam logic [1:0] RSP_MISS  = 2'd0;
    localparam logic [1:0] RSP_CLEAN = 2'd1;
    localparam logic [1:0] RSP_DIRTY = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LKUP = 3'd1,
        ST_EVAL = 3'd2,
        ST_DATA = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [2:0]      op_r;
    logic [AW-1:0]   addr_r;
    logic [1:0]      rsp_r;
    logic [LW-1:0]   data_r;
    logic            hit_s;
    logic            legal_s;
    logic            act_s;

    // A read snoop leaves a shared copy behind; RFO and INV always invalidate.
    function automatic logic [2:0] snoop_next_st(input logic [2:0] op);
        logic [2:0] st;
        case (op)
            SDREQ_RD:  st = MESI_S;
            SDREQ_RFO: st = MESI_I;
            SDREQ_INV: st = MESI_I;
            default:   st = MESI_I;
        endcase
        return st;
    endfunction

    // A tag match on an INVALID block counts as a miss; unknown ops are never acted on.
    assign hit_s   = lkup_hit && (lkup_st != MESI_I);
    assign legal_s = (op_r == SDREQ_RD) || (op_r == SDREQ_RFO) || (op_r == SDREQ_INV);
    assign act_s   = hit_s && legal_s;

    // All array addresses come from the latched request address.
    assign lkup_addr   = addr_r;
    assign dat_rd_addr = addr_r;
    assign upd_addr    = addr_r;
    assign sdrsp_rsp   = rsp_r;
    assign sdrsp_data  = data_r;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and strobe decode
    always_comb begin
        state_nxt_s = state_r;
        sureq_ready = 1'b0;
        lkup_valid  = 1'b0;
        dat_rd_en   = 1'b0;
        upd_valid   = 1'b0;
        upd_st      = MESI_I;
        sdrsp_valid = 1'b0;
        snp_busy    = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                // Not ready while reset is held, even though the state reads IDLE.
                sureq_ready = ~rst;
                if (sureq_valid) begin
                    state_nxt_s = ST_LKUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LKUP: begin
                lkup_valid  = 1'b1;
                state_nxt_s = ST_EVAL;
            end
            ST_EVAL: begin
                if (act_s) begin
                    upd_valid = 1'b1;
                    upd_st    = snoop_next_st(op_r);
                    if (lkup_st == MESI_M) begin
                        dat_rd_en   = 1'b1;
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_DATA: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                sdrsp_valid = 1'b1;
                if (sdrsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request latch and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= 3'd0;
            addr_r <= {AW{1'b0}};
            rsp_r  <= RSP_MISS;
            data_r <= {LW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sureq_valid) begin
                        op_r   <= sureq_op;
                        addr_r <= sureq_addr;
                    end
                end
                ST_EVAL: begin
                    if (act_s && (lkup_st == MESI_M)) begin
                        rsp_r <= RSP_DIRTY;
                    end else if (act_s) begin
                        rsp_r <= RSP_CLEAN;
                    end else begin
                        rsp_r <= RSP_MISS;
                    end
                end
                ST_DATA: begin
                    data_r <= dat_rd_data;
                    rsp_r  <= RSP_DIRTY;
                end
                ST_RESP: begin
                    if (sdrsp_ready) begin
                        data_r <= {LW{1'b0}};
                    end
                end
                default: begin
                    op_r <= op_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_snp_rsp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l1_snp_rsp_ctrl
//
// Directed bench for l1_snp_rsp_ctrl. Inputs change 1 ns after the rising
// edge and outputs are sampled at the same point. Tag and data results are
// held constant per transaction, so they are present whenever the DUT samples
// them.
// ---------------------------------------------------------------------------
module tb_l1_snp_rsp_ctrl;

    localparam int AW = 32;
    localparam int LW = 512;

    localparam logic [2:0] OP_RD  = 3'd1;
    localparam logic [2:0] OP_RFO = 3'd2;
    localparam logic [2:0] OP_INV = 3'd3;
    localparam logic [2:0] ST_I   = 3'd0;
    localparam logic [2:0] ST_S   = 3'd1;
    localparam logic [2:0] ST_E   = 3'd2;
    localparam logic [2:0] ST_M   = 3'd3;
    localparam logic [1:0] R_MISS  = 2'd0;
    localparam logic [1:0] R_CLEAN = 2'd1;
    localparam logic [1:0] R_DIRTY = 2'd2;

    logic          clk;
    logic          rst;
    logic          sureq_valid;
    logic          sureq_ready;
    logic [2:0]    sureq_op;
    logic [AW-1:0] sureq_addr;
    logic          lkup_valid;
    logic [AW-1:0] lkup_addr;
    logic          lkup_hit;
    logic [2:0]    lkup_st;
    logic          dat_rd_en;
    logic [AW-1:0] dat_rd_addr;
    logic [LW-1:0] dat_rd_data;
    logic          upd_valid;
    logic [AW-1:0] upd_addr;
    logic [2:0]    upd_st;
    logic          sdrsp_valid;
    logic          sdrsp_ready;
    logic [1:0]    sdrsp_rsp;
    logic [LW-1:0] sdrsp_data;
    logic          snp_busy;

    int n_chk;
    int n_fail;
    int n_upd;
    int n_rd;
    int n_hs;
    int upd0;
    int rd0;
    int hs0;

    logic [LW-1:0] pat_a;
    logic [LW-1:0] pat_b;

    l1_snp_rsp_ctrl #(.AW(AW), .LW(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sureq_valid (sureq_valid),
        .sureq_ready (sureq_ready),
        .sureq_op    (sureq_op),
        .sureq_addr  (sureq_addr),
        .lkup_valid  (lkup_valid),
        .lkup_addr   (lkup_addr),
        .lkup_hit    (lkup_hit),
        .lkup_st     (lkup_st),
        .dat_rd_en   (dat_rd_en),
        .dat_rd_addr (dat_rd_addr),
        .dat_rd_data (dat_rd_data),
        .upd_valid   (upd_valid),
        .upd_addr    (upd_addr),
        .upd_st      (upd_st),
        .sdrsp_valid (sdrsp_valid),
        .sdrsp_ready (sdrsp_ready),
        .sdrsp_rsp   (sdrsp_rsp),
        .sdrsp_data  (sdrsp_data),
        .snp_busy    (snp_busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event counters for strobes and response handshakes
    initial begin
        n_upd = 0;
        n_rd  = 0;
        n_hs  = 0;
    end
    always @(posedge clk) begin
        if (upd_valid)                  n_upd <= n_upd + 1;
        if (dat_rd_en)                  n_rd  <= n_rd + 1;
        if (sdrsp_valid && sdrsp_ready) n_hs  <= n_hs + 1;
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle (cycle T) and advance to T+1.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic hit, input logic [2:0] st, input logic [LW-1:0] data);
        lkup_hit    = hit;
        lkup_st     = st;
        dat_rd_data = data;
        sureq_op    = op;
        sureq_addr  = addr;
        sureq_valid = 1'b1;
        chk("accept_ready", LW'(sureq_ready), LW'(1'b1));
        tick();
        sureq_valid = 1'b0;
        sureq_op    = 3'd0;
        sureq_addr  = 32'd0;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        pat_a       = {16'hDEAD, {15{32'h0123_4567}}, 16'hBEEF};
        pat_b       = {16{32'hA5A5_5A5A}};
        rst         = 1'b1;
        sureq_valid = 1'b0;
        sureq_op    = 3'd0;
        sureq_addr  = 32'd0;
        lkup_hit    = 1'b0;
        lkup_st     = ST_I;
        dat_rd_data = {LW{1'b0}};
        sdrsp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_ready",  LW'(sureq_ready), LW'(1'b0));
        chk("rst_busy",   LW'(snp_busy),    LW'(1'b0));
        chk("rst_rspv",   LW'(sdrsp_valid), LW'(1'b0));
        chk("rst_data",   sdrsp_data,       {LW{1'b0}});
        rst = 1'b0;
        tick();
        chk("idle_ready", LW'(sureq_ready), LW'(1'b1));

        // 1: RD to E block -> S, HIT_CLEAN at T+3, ready again at T+4
        issue(OP_RD, 32'h100, 1'b1, ST_E, pat_b);
        chk("t1_lkv",   LW'(lkup_valid), LW'(1'b1));
        chk("t1_lka",   LW'(lkup_addr),  LW'(32'h100));
        chk("t1_busy",  LW'(snp_busy),   LW'(1'b1));
        chk("t1_rdy1",  LW'(sureq_ready), LW'(1'b0));
        tick();
        chk("t1_updv",  LW'(upd_valid),  LW'(1'b1));
        chk("t1_upds",  LW'(upd_st),     LW'(ST_S));
        chk("t1_upda",  LW'(upd_addr),   LW'(32'h100));
        chk("t1_rden",  LW'(dat_rd_en),  LW'(1'b0));
        tick();
        chk("t1_rspv",  LW'(sdrsp_valid), LW'(1'b1));
        chk("t1_rsp",   LW'(sdrsp_rsp),   LW'(R_CLEAN));
        chk("t1_updv3", LW'(upd_valid),   LW'(1'b0));
        tick();
        chk("t1_rdy4",  LW'(sureq_ready), LW'(1'b1));
        chk("t1_rspv4", LW'(sdrsp_valid), LW'(1'b0));

        // 2: RFO to M block -> I, data flushed, HIT_DIRTY at T+4
        issue(OP_RFO, 32'h200, 1'b1, ST_M, pat_a);
        tick();
        chk("t2_updv",  LW'(upd_valid),   LW'(1'b1));
        chk("t2_upds",  LW'(upd_st),      LW'(ST_I));
        chk("t2_rden",  LW'(dat_rd_en),   LW'(1'b1));
        chk("t2_rda",   LW'(dat_rd_addr), LW'(32'h200));
        tick();
        chk("t2_rspv3", LW'(sdrsp_valid), LW'(1'b0));
        chk("t2_rden3", LW'(dat_rd_en),   LW'(1'b0));
        tick();
        chk("t2_rspv",  LW'(sdrsp_valid), LW'(1'b1));
        chk("t2_rsp",   LW'(sdrsp_rsp),   LW'(R_DIRTY));
        chk("t2_data",  sdrsp_data,       pat_a);
        tick();
        chk("t2_rdy5",  LW'(sureq_ready), LW'(1'b1));
        chk("t2_dclr",  sdrsp_data,       {LW{1'b0}});

        // 3: INV with tag match on an INVALID block -> MISS, no strobes
        upd0 = n_upd;
        rd0  = n_rd;
        issue(OP_INV, 32'h340, 1'b1, ST_I, pat_b);
        tick();
        tick();
        chk("t3_rspv",  LW'(sdrsp_valid), LW'(1'b1));
        chk("t3_rsp",   LW'(sdrsp_rsp),   LW'(R_MISS));
        tick();
        chk("t3_nupd",  LW'(n_upd - upd0), LW'(0));
        chk("t3_nrd",   LW'(n_rd - rd0),   LW'(0));
        chk("t3_rdy",   LW'(sureq_ready),  LW'(1'b1));

        // 4: RD to M block with response back-pressured 5 cycles
        sdrsp_ready = 1'b0;
        upd0 = n_upd;
        rd0  = n_rd;
        hs0  = n_hs;
        issue(OP_RD, 32'h480, 1'b1, ST_M, pat_b);
        tick();
        chk("t4_upds",  LW'(upd_st),    LW'(ST_S));
        chk("t4_rden",  LW'(dat_rd_en), LW'(1'b1));
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_v",   LW'(sdrsp_valid), LW'(1'b1));
            chk("t4_hold_rsp", LW'(sdrsp_rsp),   LW'(R_DIRTY));
            chk("t4_hold_dat", sdrsp_data,       pat_b);
            chk("t4_hold_rdy", LW'(sureq_ready), LW'(1'b0));
            if (i < 4) tick();
        end
        sdrsp_ready = 1'b1;
        tick();
        chk("t4_nhs",   LW'(n_hs - hs0),   LW'(1));
        chk("t4_nupd",  LW'(n_upd - upd0), LW'(1));
        chk("t4_nrd",   LW'(n_rd - rd0),   LW'(1));
        chk("t4_rspv",  LW'(sdrsp_valid),  LW'(1'b0));
        chk("t4_rdy",   LW'(sureq_ready),  LW'(1'b1));

        // 5: reset asserted while in DATA of an RFO to M
        issue(OP_RFO, 32'h5C0, 1'b1, ST_M, pat_a);
        tick();
        tick();
        chk("t5_busy",  LW'(snp_busy), LW'(1'b1));
        upd0 = n_upd;
        hs0  = n_hs;
        rst  = 1'b1;
        #1;
        chk("t5_rdy",   LW'(sureq_ready), LW'(1'b0));
        chk("t5_busy0", LW'(snp_busy),    LW'(1'b0));
        chk("t5_rspv",  LW'(sdrsp_valid), LW'(1'b0));
        chk("t5_rsp",   LW'(sdrsp_rsp),   LW'(R_MISS));
        chk("t5_data",  sdrsp_data,       {LW{1'b0}});
        chk("t5_lkv",   LW'(lkup_valid),  LW'(1'b0));
        chk("t5_rden",  LW'(dat_rd_en),   LW'(1'b0));
        chk("t5_updv",  LW'(upd_valid),   LW'(1'b0));
        chk("t5_upds",  LW'(upd_st),      LW'(ST_I));
        chk("t5_lka",   LW'(lkup_addr),   LW'(32'h0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("t5_nhs",   LW'(n_hs - hs0),   LW'(0));
        chk("t5_nupd",  LW'(n_upd - upd0), LW'(0));
        chk("t5_rspv2", LW'(sdrsp_valid),  LW'(1'b0));

        // 6: illegal op to S block after reset -> served, MISS, no update
        upd0 = n_upd;
        rd0  = n_rd;
        hs0  = n_hs;
        issue(3'b111, 32'h600, 1'b1, ST_S, pat_b);
        chk("t6_lkv",   LW'(lkup_valid), LW'(1'b1));
        chk("t6_lka",   LW'(lkup_addr),  LW'(32'h600));
        tick();
        chk("t6_updv",  LW'(upd_valid),  LW'(1'b0));
        tick();
        chk("t6_rspv",  LW'(sdrsp_valid), LW'(1'b1));
        chk("t6_rsp",   LW'(sdrsp_rsp),   LW'(R_MISS));
        tick();
        chk("t6_nupd",  LW'(n_upd - upd0), LW'(0));
        chk("t6_nrd",   LW'(n_rd - rd0),   LW'(0));
        chk("t6_nhs",   LW'(n_hs - hs0),   LW'(1));
        chk("t6_rdy",   LW'(sureq_ready),  LW'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
